data_mem_arbiter: RTL and testbench
===================================

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 SHALL have parameter PRIORITY_MODE, default 0, meaning 0 = round-robin and 1 = fixed priority with m0 always winning.
REQ-002 SHALL have clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have m0_req_i / m1_req_i, input, 1 each, master request.
REQ-005 SHALL have m0_addr_i / m1_addr_i, input, 32 each, byte address.
REQ-006 SHALL have m0_we_i / m1_we_i, input, 1 each, write enable.
REQ-007 SHALL have m0_be_i / m1_be_i, input, 4 each, byte enables.
REQ-008 SHALL have m0_wdata_i / m1_wdata_i, input, 32 each, write data.
REQ-009 SHALL have m0_gnt_o / m1_gnt_o, output, 1 each, request accepted.
REQ-010 SHALL have m0_rvalid_o / m1_rvalid_o, output, 1 each, response valid.
REQ-011 SHALL have m0_rdata_o / m1_rdata_o, output, 32 each, read data.
REQ-012 SHALL have data_req_o, output, 1; data_addr_o, output, 32; data_we_o, output, 1; data_be_o, output, 4; data_wdata_o, output, 32; all are the shared memory request.
REQ-013 SHALL have data_gnt_i, input, 1; data_rvalid_i, input, 1; data_rdata_i, input, 32; all are the shared memory response.
REQ-014 SHALL have busy_o, output, 1, state not IDLE; owner_o, output, 1, current or last owner (0 = m0).

Function
REQ-015 SHALL implement FSM states S_IDLE, S_WAIT_GNT and S_WAIT_RVALID, with exactly one transaction outstanding at a time.
REQ-016 In S_IDLE with any mi_req_i=1, SHALL select a winner combinationally, forward its addr/we/be/wdata with data_req_o=1 in the same cycle, and register the winner into owner.
REQ-017 Round-robin arbitration: on a tie, the master not granted last SHALL win; a single requester SHALL always win. Fixed-priority arbitration: m0 SHALL win every tie.
REQ-018 The winner's mi_gnt_o SHALL equal data_gnt_i combinationally while data_req_o=1; the loser's gnt SHALL be 0.
REQ-019 From S_IDLE or S_WAIT_GNT, data_gnt_i=1 SHALL move the FSM to S_WAIT_RVALID and update last_grant=owner; data_gnt_i=0 SHALL move it to (or hold it in) S_WAIT_GNT.
REQ-020 In S_WAIT_GNT, the owner SHALL be locked and its request fields forwarded even if the other master requests; data_req_o SHALL equal the owner's req.
REQ-021 In S_WAIT_GNT, if the owner drops req, the FSM SHALL return to S_IDLE with no transaction and last_grant unchanged.
REQ-022 In S_WAIT_RVALID, data_req_o SHALL be 0 and data_addr_o/we/be/wdata SHALL be 0; mi_gnt_o SHALL be 0 for both masters.
REQ-023 In S_WAIT_RVALID with data_rvalid_i=1, the owner's rvalid_o SHALL be 1 and its rdata_o SHALL equal data_rdata_i in the same cycle, and the next state SHALL be S_IDLE.
REQ-024 A new request SHALL be forwarded no earlier than the cycle after rvalid, giving a minimum of 2 cycles per transaction.
REQ-025 A non-owner's rvalid_o SHALL be 0 and its rdata_o SHALL be 32'h0 at all times.
REQ-026 data_rvalid_i seen in S_IDLE or S_WAIT_GNT SHALL be ignored and not forwarded to either master.
REQ-027 When data_req_o=0, data_addr_o, data_we_o, data_be_o and data_wdata_o SHALL be 0.
REQ-028 The arbiter SHALL not modify any forwarded field: width 32/4/1 pass-through with no offset.

Reset
REQ-029 On reset=1 at a clock edge: state SHALL be S_IDLE, owner=0, last_grant=1 (so m0 wins the first tie); all outputs SHALL be 0 in the following cycle unless a request is present.
REQ-030 Reset asserted mid-transaction SHALL abandon that transaction; a late data_rvalid_i after reset SHALL be dropped per REQ-026.

Verification
REQ-031 m0 read of 0x600 with gnt in the same cycle and rvalid 2 cycles later with rdata 0xDEADBEEF -> m0_gnt_o=1 in cycle 0, m0_rvalid_o=1 with m0_rdata_o=0xDEADBEEF, and m1 outputs remain 0.
REQ-032 Both masters requesting continuously with PRIORITY_MODE=0 -> owner order m0, m1, m0, m1; with PRIORITY_MODE=1 -> m0 always wins.
REQ-033 m1 write of 0x604 with be=4'b0011 and data_gnt_i held low 3 cycles while m0 requests -> data_addr_o stays 0x604 and data_be_o=4'b0011 throughout; m0_gnt_o=0.
REQ-034 m0 drops req while in S_WAIT_GNT -> the FSM returns to S_IDLE, busy_o=0, and the next tie is granted to m0.
REQ-035 Reset pulsed in S_WAIT_RVALID followed by data_rvalid_i=1 -> both mi_rvalid_o=0 and the state is S_IDLE.
REQ-036 data_rvalid_i=1 while in S_IDLE -> no rvalid is forwarded and the state is unchanged.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - two-master arbiter onto a single data memory port, one transaction in flight
module data_mem_arbiter #(
    parameter int PRIORITY_MODE = 0
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_req_i,
    input  logic [31:0] m0_addr_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_be_i,
    input  logic [31:0] m0_wdata_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,

    input  logic        m1_req_i,
    input  logic [31:0] m1_addr_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,

    output logic        data_req_o,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i,

    output logic        busy_o,
    output logic        owner_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_GNT,
        S_WAIT_RVALID
    } state_t;

    state_t state, state_next;
    logic   owner, owner_next;
    logic   last_grant, last_grant_next;
    logic   winner;
    logic   sel;
    logic   req_active;
    logic   resp_valid;

    // Winner for a fresh arbitration; a lone requester always wins, ties go by mode
    always_comb begin
        winner = 1'b0;
        if (m0_req_i && m1_req_i) begin
            winner = (PRIORITY_MODE == 1) ? 1'b0 : ~last_grant;
        end else if (m1_req_i) begin
            winner = 1'b1;
        end
    end

    // Next-state logic: pick the forwarded master and decide whether the request is live
    always_comb begin
        state_next      = state;
        owner_next      = owner;
        last_grant_next = last_grant;
        sel             = owner;
        req_active      = 1'b0;
        case (state)
            S_IDLE: begin
                sel = winner;
                if (m0_req_i || m1_req_i) begin
                    req_active = 1'b1;
                    owner_next = winner;
                    if (data_gnt_i) begin
                        state_next      = S_WAIT_RVALID;
                        last_grant_next = winner;
                    end else begin
                        state_next = S_WAIT_GNT;
                    end
                end
            end
            S_WAIT_GNT: begin
                // Owner stays locked; withdrawing the request abandons it without touching fairness
                req_active = owner ? m1_req_i : m0_req_i;
                if (!req_active) begin
                    state_next = S_IDLE;
                end else if (data_gnt_i) begin
                    state_next      = S_WAIT_RVALID;
                    last_grant_next = owner;
                end
            end
            S_WAIT_RVALID: begin
                if (data_rvalid_i) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State, owner and fairness registers; last_grant starts at m1 so m0 takes the first tie
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            state      <= state_next;
            owner      <= owner_next;
            last_grant <= last_grant_next;
        end
    end

    // Memory-side request mux and master-side grant/response steering, zeroed when idle
    always_comb begin
        data_req_o   = req_active;
        data_addr_o  = 32'h0;
        data_we_o    = 1'b0;
        data_be_o    = 4'h0;
        data_wdata_o = 32'h0;
        if (req_active) begin
            data_addr_o  = sel ? m1_addr_i  : m0_addr_i;
            data_we_o    = sel ? m1_we_i    : m0_we_i;
            data_be_o    = sel ? m1_be_i    : m0_be_i;
            data_wdata_o = sel ? m1_wdata_i : m0_wdata_i;
        end
        m0_gnt_o    = req_active && data_gnt_i && !sel;
        m1_gnt_o    = req_active && data_gnt_i &&  sel;
        resp_valid  = (state == S_WAIT_RVALID) && data_rvalid_i;
        m0_rvalid_o = resp_valid && !owner;
        m1_rvalid_o = resp_valid &&  owner;
        m0_rdata_o  = m0_rvalid_o ? data_rdata_i : 32'h0;
        m1_rdata_o  = m1_rvalid_o ? data_rdata_i : 32'h0;
        busy_o      = (state != S_IDLE);
        owner_o     = owner;
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - scoreboard bench for data_mem_arbiter in both arbitration modes
module tb_data_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        m0_req_i, m1_req_i;
    logic [31:0] m0_addr_i, m1_addr_i;
    logic        m0_we_i, m1_we_i;
    logic [3:0]  m0_be_i, m1_be_i;
    logic [31:0] m0_wdata_i, m1_wdata_i;
    logic        data_gnt_i, data_rvalid_i;
    logic [31:0] data_rdata_i;

    logic        m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        data_req_o, data_we_o, busy_o, owner_o;
    logic [31:0] data_addr_o, data_wdata_o;
    logic [3:0]  data_be_o;

    logic        fp_m0_gnt, fp_m1_gnt, fp_m0_rvalid, fp_m1_rvalid;
    logic [31:0] fp_m0_rdata, fp_m1_rdata;
    logic        fp_data_req, fp_data_we, fp_busy, fp_owner;
    logic [31:0] fp_data_addr, fp_data_wdata;
    logic [3:0]  fp_data_be;

    typedef struct packed {
        logic        is_rsp;
        logic        master;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    data_mem_arbiter #(.PRIORITY_MODE(0)) dut_rr (
        .clk(clk), .reset(reset),
        .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i),
        .m0_wdata_i(m0_wdata_i), .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i),
        .m1_wdata_i(m1_wdata_i), .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
        .data_req_o(data_req_o), .data_addr_o(data_addr_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
        .data_wdata_o(data_wdata_o), .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
        .data_rdata_i(data_rdata_i), .busy_o(busy_o), .owner_o(owner_o)
    );

    data_mem_arbiter #(.PRIORITY_MODE(1)) dut_fp (
        .clk(clk), .reset(reset),
        .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i),
        .m0_wdata_i(m0_wdata_i), .m0_gnt_o(fp_m0_gnt), .m0_rvalid_o(fp_m0_rvalid), .m0_rdata_o(fp_m0_rdata),
        .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i),
        .m1_wdata_i(m1_wdata_i), .m1_gnt_o(fp_m1_gnt), .m1_rvalid_o(fp_m1_rvalid), .m1_rdata_o(fp_m1_rdata),
        .data_req_o(fp_data_req), .data_addr_o(fp_data_addr), .data_we_o(fp_data_we), .data_be_o(fp_data_be),
        .data_wdata_o(fp_data_wdata), .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
        .data_rdata_i(data_rdata_i), .busy_o(fp_busy), .owner_o(fp_owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic push_gnt(input logic m, input logic [31:0] a, input logic w,
                            input logic [3:0] b, input logic [31:0] d);
        exp_t e;
        e = '{is_rsp: 1'b0, master: m, addr: a, we: w, be: b, wdata: d, rdata: 32'h0};
        exp_q.push_back(e);
    endtask

    task automatic push_rsp(input logic m, input logic [31:0] r);
        exp_t e;
        e = '{is_rsp: 1'b1, master: m, addr: 32'h0, we: 1'b0, be: 4'h0, wdata: 32'h0, rdata: r};
        exp_q.push_back(e);
    endtask

    task automatic set_m0(input logic r, input logic [31:0] a, input logic w,
                          input logic [3:0] b, input logic [31:0] d);
        m0_req_i = r; m0_addr_i = a; m0_we_i = w; m0_be_i = b; m0_wdata_i = d;
    endtask

    task automatic set_m1(input logic r, input logic [31:0] a, input logic w,
                          input logic [3:0] b, input logic [31:0] d);
        m1_req_i = r; m1_addr_i = a; m1_we_i = w; m1_be_i = b; m1_wdata_i = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard whenever the round-robin instance grants or responds
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (m0_gnt_o || m1_gnt_o) begin
                chk("gnt_both", 32'(m0_gnt_o & m1_gnt_o), 32'd0);
                if (exp_q.size() == 0) begin
                    chk("gnt_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("gnt_order", 32'(e.is_rsp), 32'd0);
                    chk("gnt_master", 32'(m1_gnt_o), 32'(e.master));
                    chk("gnt_addr", data_addr_o, e.addr);
                    chk("gnt_we", 32'(data_we_o), 32'(e.we));
                    chk("gnt_be", 32'(data_be_o), 32'(e.be));
                    chk("gnt_wdata", data_wdata_o, e.wdata);
                end
            end
            if (m0_rvalid_o || m1_rvalid_o) begin
                chk("rvalid_both", 32'(m0_rvalid_o & m1_rvalid_o), 32'd0);
                if (exp_q.size() == 0) begin
                    chk("rvalid_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_order", 32'(e.is_rsp), 32'd1);
                    chk("rsp_master", 32'(m1_rvalid_o), 32'(e.master));
                    chk("rsp_rdata", m1_rvalid_o ? m1_rdata_o : m0_rdata_o, e.rdata);
                end
            end
            if (!m0_rvalid_o) chk("m0_rdata_idle", m0_rdata_o, 32'h0);
            if (!m1_rvalid_o) chk("m1_rdata_idle", m1_rdata_o, 32'h0);
            if (!data_req_o) begin
                chk("idle_addr", data_addr_o, 32'h0);
                chk("idle_fields", {27'h0, data_we_o, data_be_o}, 32'h0);
                chk("idle_wdata", data_wdata_o, 32'h0);
            end
        end
    end

    initial begin
        reset = 1'b1;
        set_m0(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        set_m1(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = 32'h0;
        step();
        step();
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_owner", 32'(owner_o), 32'd0);
        chk("rst_req", 32'(data_req_o), 32'd0);
        chk("rst_gnt", 32'({m0_gnt_o, m1_gnt_o}), 32'd0);
        chk("rst_rvalid", 32'({m0_rvalid_o, m1_rvalid_o}), 32'd0);

        // m0 read 0x600, same-cycle gnt, rvalid two cycles later
        step();
        set_m0(1'b1, 32'h600, 1'b0, 4'hF, 32'h0);
        data_gnt_i = 1'b1;
        push_gnt(1'b0, 32'h600, 1'b0, 4'hF, 32'h0);
        push_rsp(1'b0, 32'hDEADBEEF);
        @(negedge clk);
        chk("rd_m0_gnt", 32'(m0_gnt_o), 32'd1);
        chk("rd_m1_gnt", 32'(m1_gnt_o), 32'd0);
        step();
        set_m0(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        data_gnt_i = 1'b0;
        @(negedge clk);
        chk("rd_wait_busy", 32'(busy_o), 32'd1);
        chk("rd_wait_req", 32'(data_req_o), 32'd0);
        step();
        data_rvalid_i = 1'b1; data_rdata_i = 32'hDEADBEEF;
        @(negedge clk);
        chk("rd_m0_rvalid", 32'(m0_rvalid_o), 32'd1);
        chk("rd_m0_rdata", m0_rdata_o, 32'hDEADBEEF);
        chk("rd_m1_rvalid", 32'(m1_rvalid_o), 32'd0);
        chk("rd_m1_rdata", m1_rdata_o, 32'h0);
        step();
        data_rvalid_i = 1'b0; data_rdata_i = 32'h0;
        @(negedge clk);
        chk("rd_done_busy", 32'(busy_o), 32'd0);

        // m1 write 0x604 stalled three cycles while m0 also requests
        step();
        set_m0(1'b1, 32'h700, 1'b0, 4'hF, 32'hAAAA);
        set_m1(1'b1, 32'h604, 1'b1, 4'b0011, 32'hCAFEF00D);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_addr", data_addr_o, 32'h604);
            chk("stall_be", 32'(data_be_o), 32'h3);
            chk("stall_req", 32'(data_req_o), 32'd1);
            chk("stall_m0_gnt", 32'(m0_gnt_o), 32'd0);
            step();
        end
        data_gnt_i = 1'b1;
        push_gnt(1'b1, 32'h604, 1'b1, 4'b0011, 32'hCAFEF00D);
        push_rsp(1'b1, 32'h12345678);
        @(negedge clk);
        chk("stall_m0_gnt_final", 32'(m0_gnt_o), 32'd0);
        step();
        set_m0(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        set_m1(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        data_gnt_i = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = 32'h12345678;
        @(negedge clk);
        chk("wr_owner", 32'(owner_o), 32'd1);
        chk("wr_m0_rvalid", 32'(m0_rvalid_o), 32'd0);
        step();
        data_rvalid_i = 1'b0; data_rdata_i = 32'h0;

        // m0 abandons its request in WAIT_GNT; the following tie still goes to m0
        set_m0(1'b1, 32'h800, 1'b0, 4'hF, 32'h0);
        @(negedge clk);
        chk("abort_req", 32'(data_req_o), 32'd1);
        step();
        set_m0(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        @(negedge clk);
        chk("abort_busy_wait", 32'(busy_o), 32'd1);
        step();
        @(negedge clk);
        chk("abort_busy_idle", 32'(busy_o), 32'd0);
        step();
        set_m0(1'b1, 32'h804, 1'b0, 4'hF, 32'h0);
        set_m1(1'b1, 32'h904, 1'b0, 4'hF, 32'h0);
        data_gnt_i = 1'b1;
        push_gnt(1'b0, 32'h804, 1'b0, 4'hF, 32'h0);
        push_rsp(1'b0, 32'h0BADF00D);
        @(negedge clk);
        chk("abort_tie_m0", 32'(m0_gnt_o), 32'd1);
        step();
        set_m0(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        set_m1(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        data_gnt_i = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = 32'h0BADF00D;
        @(negedge clk);
        chk("abort_tie_rvalid", 32'(m0_rvalid_o), 32'd1);
        step();
        data_rvalid_i = 1'b0; data_rdata_i = 32'h0;

        // Stray rvalid in IDLE is dropped
        data_rvalid_i = 1'b1; data_rdata_i = 32'h55;
        @(negedge clk);
        chk("stray_rvalid", 32'({m0_rvalid_o, m1_rvalid_o}), 32'd0);
        chk("stray_busy", 32'(busy_o), 32'd0);
        step();
        data_rvalid_i = 1'b0; data_rdata_i = 32'h0;
        @(negedge clk);
        chk("stray_busy_after", 32'(busy_o), 32'd0);

        // Reset in WAIT_RVALID, then a late rvalid
        step();
        set_m0(1'b1, 32'hA00, 1'b0, 4'hF, 32'h0);
        data_gnt_i = 1'b1;
        push_gnt(1'b0, 32'hA00, 1'b0, 4'hF, 32'h0);
        step();
        set_m0(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        data_gnt_i = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        data_rvalid_i = 1'b1; data_rdata_i = 32'h77;
        @(negedge clk);
        chk("late_rvalid", 32'({m0_rvalid_o, m1_rvalid_o}), 32'd0);
        chk("late_busy", 32'(busy_o), 32'd0);
        step();
        data_rvalid_i = 1'b0; data_rdata_i = 32'h0;
        @(negedge clk);
        chk("late_busy_after", 32'(busy_o), 32'd0);

        // Continuous contention: round-robin alternates, fixed priority always m0
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        set_m0(1'b1, 32'h100, 1'b0, 4'hF, 32'h11);
        set_m1(1'b1, 32'h200, 1'b1, 4'hC, 32'h22);
        data_gnt_i = 1'b1; data_rvalid_i = 1'b1; data_rdata_i = 32'hA5A50000;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) begin
                push_gnt(1'b0, 32'h100, 1'b0, 4'hF, 32'h11);
                push_rsp(1'b0, 32'hA5A50000);
            end else begin
                push_gnt(1'b1, 32'h200, 1'b1, 4'hC, 32'h22);
                push_rsp(1'b1, 32'hA5A50000);
            end
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("fp_m0_gnt", 32'(fp_m0_gnt), 32'd1);
            chk("fp_m1_gnt", 32'(fp_m1_gnt), 32'd0);
            @(negedge clk);
            chk("rr_owner_order", 32'(owner_o), 32'(k % 2));
            chk("fp_owner", 32'(fp_owner), 32'd0);
            chk("fp_m0_rvalid", 32'(fp_m0_rvalid), 32'd1);
        end
        step();
        set_m0(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        set_m1(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = 32'h0;
        @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        chk("end_busy", 32'(busy_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
